// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg : opcodes, state encodings and select codes shared by the
//                 multicycle MIPS control, ALU control and datapath.
// Optional feature macro: MIPS_CTRL_BNE_EN (adds bne / BRANCHNE support).
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BRANCHNE = 4'd12
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
`ifdef MIPS_CTRL_BNE_EN
    logic       branch_ne;
`endif
    logic       illegal_op;
  } ctrl_t;

  // DECODE dispatch; an unsupported opcode returns to FETCH.
  function automatic state_e decode_op(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_EXECUTE;
      OP_BEQ:       nxt = S_BRANCH;
      OP_ADDI:      nxt = S_ADDIEX;
      OP_J:         nxt = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE:       nxt = S_BRANCHNE;
`endif
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_wait_cnt.sv
// ============================================================================
// mips_ctrl_wait_cnt : 4-bit wait counter that flags the last cycle of a
//                      fixed-latency memory access.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_ctrl_wait_cnt #(
  parameter int unsigned LIMIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic inc_i,
  output logic done_o
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LIMIT_C);

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_main_control.sv
// ============================================================================
// mips_multicycle_main_control : Moore main-control FSM for the multicycle
//                                MIPS datapath with fixed memory latency.
// Optional feature macro: MIPS_CTRL_BNE_EN (bne support, BranchNe port).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       illegal_op,
`ifdef MIPS_CTRL_BNE_EN
  output logic       BranchNe,
`endif
  output logic [3:0] state_o
);

  state_e state_q;
  state_e state_d;
  logic   in_wait;
  logic   wait_done;
  ctrl_t  ctrl;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD);

  // Counter holds zero outside the wait states, so each entry starts fresh.
  mips_ctrl_wait_cnt #(
    .LIMIT (MEM_LAT - 1)
  ) u_wait_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (!in_wait || wait_done),
    .inc_i  (in_wait),
    .done_o (wait_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (wait_done) state_d = S_DECODE;
      S_DECODE:  state_d = decode_op(Op);
      S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (wait_done) state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = wait_done;
        ctrl.pc_write  = wait_done;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMMSH;
        ctrl.illegal_op = (decode_op(Op) == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      S_BRANCHNE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch_ne = 1'b1;
      end
`endif
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl.pc_src = PCSRC_ALURES;
    endcase

    // Reset abandons the instruction: no strobe may fire on the reset edge.
    if (reset) begin
      ctrl.ir_write   = 1'b0;
      ctrl.pc_write   = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.reg_write  = 1'b0;
      ctrl.branch     = 1'b0;
      ctrl.illegal_op = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
      ctrl.branch_ne  = 1'b0;
`endif
    end
  end

  assign ALUOp      = ctrl.alu_op;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign PCSrc      = ctrl.pc_src;
  assign IorD       = ctrl.iord;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign PCWrite    = ctrl.pc_write;
  assign Branch     = ctrl.branch;
  assign illegal_op = ctrl.illegal_op;
`ifdef MIPS_CTRL_BNE_EN
  assign BranchNe   = ctrl.branch_ne;
`endif
  assign state_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_main_control.sv
// ============================================================================
// tb_mips_multicycle_main_control : randomized self-checking bench for the
//                                   multicycle MIPS main control (MEM_LAT=3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_main_control;
  import mips_ctrl_pkg::*;

  localparam int ML = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'h00;
  logic [1:0] ALUOp, ALUSrcB, PCSrc;
  logic       ALUSrcA, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       PCWrite, Branch, illegal_op, BranchNe;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_multicycle_main_control #(.MEM_LAT(ML)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .ALUOp      (ALUOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .illegal_op (illegal_op),
`ifdef MIPS_CTRL_BNE_EN
    .BranchNe   (BranchNe),
`endif
    .state_o    (state_o)
  );

`ifndef MIPS_CTRL_BNE_EN
  assign BranchNe = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       iord, memw, irw, regdst, m2r, regw, pcw, br, brne, ill;
  } obs_t;

  typedef struct packed {
    state_e st;
    logic   last;
    logic   ill;
  } step_t;

  int    checks = 0;
  int    errors = 0;
  step_t plan_q[$];
  obs_t  obs_q[$];
  obs_t  exp_cur;
  bit    exp_valid = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic obs_t dut_now();
    obs_t o;
    o = '{st: state_o, aluop: ALUOp, srca: ALUSrcA, srcb: ALUSrcB, pcsrc: PCSrc,
          iord: IorD, memw: MemWrite, irw: IRWrite, regdst: RegDst, m2r: MemtoReg,
          regw: RegWrite, pcw: PCWrite, br: Branch, brne: BranchNe, ill: illegal_op};
    return o;
  endfunction

  // Instruction-level model: the cycle-by-cycle phase list an opcode walks through.
  function automatic void build_plan(input logic [5:0] op);
    bit legal;
    plan_q.delete();
    for (int k = 0; k < ML; k++) plan_q.push_back('{st: S_FETCH, last: (k == ML - 1), ill: 1'b0});
    legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
            (op == 6'h08) || (op == 6'h02);
`ifdef MIPS_CTRL_BNE_EN
    if (op == 6'h05) legal = 1'b1;
`endif
    plan_q.push_back('{st: S_DECODE, last: 1'b0, ill: !legal});
    case (op)
      6'h23: begin
        plan_q.push_back('{st: S_MEMADR, last: 1'b0, ill: 1'b0});
        for (int k = 0; k < ML; k++) plan_q.push_back('{st: S_MEMRD, last: 1'b0, ill: 1'b0});
        plan_q.push_back('{st: S_MEMWB, last: 1'b0, ill: 1'b0});
      end
      6'h2B: begin
        plan_q.push_back('{st: S_MEMADR, last: 1'b0, ill: 1'b0});
        plan_q.push_back('{st: S_MEMWR, last: 1'b0, ill: 1'b0});
      end
      6'h00: begin
        plan_q.push_back('{st: S_EXECUTE, last: 1'b0, ill: 1'b0});
        plan_q.push_back('{st: S_ALUWB, last: 1'b0, ill: 1'b0});
      end
      6'h08: begin
        plan_q.push_back('{st: S_ADDIEX, last: 1'b0, ill: 1'b0});
        plan_q.push_back('{st: S_ADDIWB, last: 1'b0, ill: 1'b0});
      end
      6'h04: plan_q.push_back('{st: S_BRANCH, last: 1'b0, ill: 1'b0});
      6'h02: plan_q.push_back('{st: S_JUMP, last: 1'b0, ill: 1'b0});
`ifdef MIPS_CTRL_BNE_EN
      6'h05: plan_q.push_back('{st: S_BRANCHNE, last: 1'b0, ill: 1'b0});
`endif
      default: ;
    endcase
  endfunction

  function automatic obs_t expect_step(input step_t s, input bit rst);
    obs_t e;
    e = '0;
    e.st = s.st;
    case (s.st)
      S_FETCH:    begin e.srcb = 2'b01; e.irw = s.last; e.pcw = s.last; end
      S_DECODE:   begin e.srcb = 2'b11; e.ill = s.ill; end
      S_MEMADR,
      S_ADDIEX:   begin e.srca = 1'b1; e.srcb = 2'b10; end
      S_MEMRD:    e.iord = 1'b1;
      S_MEMWR:    begin e.iord = 1'b1; e.memw = 1'b1; end
      S_MEMWB:    begin e.regw = 1'b1; e.m2r = 1'b1; end
      S_EXECUTE:  begin e.srca = 1'b1; e.aluop = 2'b10; end
      S_ALUWB:    begin e.regdst = 1'b1; e.regw = 1'b1; end
      S_ADDIWB:   e.regw = 1'b1;
      S_BRANCH:   begin e.srca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.br = 1'b1; end
      S_BRANCHNE: begin e.srca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.brne = 1'b1; end
      S_JUMP:     begin e.pcsrc = 2'b10; e.pcw = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      e.memw = 1'b0; e.irw = 1'b0; e.regw = 1'b0; e.pcw = 1'b0;
      e.br = 1'b0; e.brne = 1'b0; e.ill = 1'b0;
    end
    return e;
  endfunction

  // Drives one instruction; rst_at selects a step on which reset is raised.
  task automatic run_instr(input logic [5:0] op, input int rst_at);
    build_plan(op);
    obs_q.delete();
    for (int i = 0; i < plan_q.size(); i++) begin
      @(posedge clk);
      #1;
      reset = (i == rst_at);
      Op = (plan_q[i].st == S_DECODE || plan_q[i].st == S_MEMADR) ? op : 6'($urandom);
      exp_cur = expect_step(plan_q[i], i == rst_at);
      exp_valid = 1'b1;
      #1 obs_q.push_back(dut_now());
      if (i == rst_at) break;
    end
  endtask

  function automatic int count_memw();
    int n = 0;
    foreach (obs_q[i]) n += obs_q[i].memw;
    return n;
  endfunction

  function automatic int count_regw();
    int n = 0;
    foreach (obs_q[i]) n += obs_q[i].regw;
    return n;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      obs_t g;
      g = dut_now();
      chk("state_o",    g.st,     exp_cur.st);
      chk("ALUOp",      g.aluop,  exp_cur.aluop);
      chk("ALUSrcA",    g.srca,   exp_cur.srca);
      chk("ALUSrcB",    g.srcb,   exp_cur.srcb);
      chk("PCSrc",      g.pcsrc,  exp_cur.pcsrc);
      chk("IorD",       g.iord,   exp_cur.iord);
      chk("MemWrite",   g.memw,   exp_cur.memw);
      chk("IRWrite",    g.irw,    exp_cur.irw);
      chk("RegDst",     g.regdst, exp_cur.regdst);
      chk("MemtoReg",   g.m2r,    exp_cur.m2r);
      chk("RegWrite",   g.regw,   exp_cur.regw);
      chk("PCWrite",    g.pcw,    exp_cur.pcw);
      chk("Branch",     g.br,     exp_cur.br);
      chk("BranchNe",   g.brne,   exp_cur.brne);
      chk("illegal_op", g.ill,    exp_cur.ill);
    end
  end

  logic [5:0] op_tab [8] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h3F};

  initial begin
    // First reset cycle: state unknown, strobes must already be quiet.
    #2;
    chk("rst_c0_strobes", {MemWrite, IRWrite, RegWrite, PCWrite, Branch, illegal_op}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_cur = expect_step('{st: S_FETCH, last: 1'b1, ill: 1'b0}, 1'b1);
    exp_valid = 1'b1;

    run_instr(6'h00, -1);
    chk("r_len", plan_q.size(), 6);
    chk("r_fetch0_irw", obs_q[0].irw, 0);
    chk("r_fetch_last_irw", obs_q[2].irw, 1);
    chk("r_fetch_last_pcw", obs_q[2].pcw, 1);
    chk("r_exec_aluop", obs_q[4].aluop, 2);
    chk("r_aluwb_regw", obs_q[5].regw, 1);
    chk("r_aluwb_regdst", obs_q[5].regdst, 1);

    run_instr(6'h23, -1);
    chk("lw_len", plan_q.size(), 9);
    chk("lw_state_c4", obs_q[3].st, 4'd1);
    chk("lw_memrd_iord", obs_q[6].iord, 1);
    chk("lw_memwb_state", obs_q[8].st, 4'd4);
    chk("lw_memwb_m2r", obs_q[8].m2r, 1);
    chk("lw_regw_count", count_regw(), 1);

    run_instr(6'h2B, -1);
    chk("sw_len", plan_q.size(), 6);
    chk("sw_memw_count", count_memw(), 1);
    chk("sw_memw_last", obs_q[5].memw, 1);
    chk("sw_regw_count", count_regw(), 0);

    run_instr(6'h04, -1);
    chk("beq_len", plan_q.size(), 5);
    chk("beq_aluop", obs_q[4].aluop, 1);
    chk("beq_pcsrc", obs_q[4].pcsrc, 1);
    chk("beq_branch", obs_q[4].br, 1);

    run_instr(6'h02, -1);
    chk("j_pcsrc", obs_q[4].pcsrc, 2);
    chk("j_pcw", obs_q[4].pcw, 1);

    run_instr(6'h3F, -1);
    chk("ill_len", plan_q.size(), 4);
    chk("ill_pulse", obs_q[3].ill, 1);

    run_instr(6'h05, -1);
`ifdef MIPS_CTRL_BNE_EN
    chk("bne_brne", obs_q[4].brne, 1);
    chk("bne_branch", obs_q[4].br, 0);
`else
    chk("bne_ill", obs_q[3].ill, 1);
    chk("bne_len", plan_q.size(), 4);
`endif

    run_instr(6'h08, -1);
    chk("addi_regw", obs_q[5].regw, 1);

    // Reset lands on the MEMWR cycle of a store.
    run_instr(6'h2B, 5);
    chk("swrst_state", obs_q[5].st, 4'd5);
    chk("swrst_memw", obs_q[5].memw, 0);
    run_instr(6'h00, -1);
    chk("after_rst_regw", count_regw(), 1);

    for (int n = 0; n < 250; n++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 7);
      op = op_tab[sel];
      if (sel == 7) op = 6'($urandom);
      run_instr(op, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 11)) : -1);
    end

    @(posedge clk);
    #1 exp_valid = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
